// File: rtl/usb_pattern_producer_pkg.sv
// Shared encodings for the FX3 slave-FIFO pattern producer: data modes, FSM states
// and the packet header magic byte.
package usb_pattern_producer_pkg;

    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_WALK  = 2'd1,
        MODE_ALT   = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WT_FIFO = 3'd1,
        ST_WR_PKT  = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_WT_DONE = 3'd4
    } state_e;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

endpackage

// File: rtl/usb_pattern_producer_gen.sv
// Pattern state holder: presents the current word of the selected pattern on dt_o
// and steps that pattern when adv_i is high; clr_i restarts every pattern.
module usb_pattern_gen
    import usb_pattern_producer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] const_i,
    output logic [DATA_W-1:0] dt_o
);

    logic [DATA_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_walk;
    logic              r_alt;

    // phase 0 gives ...1010 (A..A), phase 1 gives ...0101 (5..5)
    function automatic logic [DATA_W-1:0] alt_word(input logic phase);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W; i++) begin
            w[i] = (i % 2 == 1) ^ phase;
        end
        return w;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt  <= '0;
            r_walk <= {{(DATA_W-1){1'b0}}, 1'b1};
            r_alt  <= 1'b0;
        end else if (adv_i) begin
            case (mode_e'(mode_i))
                MODE_CNT:  r_cnt  <= r_cnt + DATA_W'(1);
                MODE_WALK: r_walk <= {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};
                MODE_ALT:  r_alt  <= ~r_alt;
                default:   ;
            endcase
        end
    end

    always_comb begin
        dt_o = r_cnt;
        case (mode_e'(mode_i))
            MODE_CNT:   dt_o = r_cnt;
            MODE_WALK:  dt_o = r_walk;
            MODE_ALT:   dt_o = alt_word(r_alt);
            MODE_CONST: dt_o = const_i;
            default:    dt_o = r_cnt;
        endcase
    end

endmodule

// File: rtl/usb_pattern_producer.sv
// FX3 slave-FIFO test-data source: alternating short/full packets with flow control.
// Optional packet header word enabled by defining USB_PROD_HDR_EN.
module usb_pattern_producer
    import usb_pattern_producer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] const_i,
    input  logic [LEN_W-1:0]  short_len_i,
    input  logic [LEN_W-1:0]  full_len_i,
    input  logic              done_i,
    input  logic              fifo_epty_i,
    input  logic              fifo_full_i,
    input  logic              fifo_almst_full_i,
    output logic              fifo_wr_o,
    output logic [DATA_W-1:0] dt_o,
    output logic              pkt_last_o,
    output logic [CNT_W-1:0]  pkt_cnt_o,
    output logic              busy_o
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_is_full;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_wcnt;
    logic [1:0]        r_mode;
    logic              r_wr;
    logic [DATA_W-1:0] r_dt;
    logic              r_last;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic              r_busy;

    logic [LEN_W-1:0]  w_cur_len;
    logic [LEN_W-1:0]  w_wcnt_nxt;
    logic              w_fifo_rdy;
    logic              w_both_zero;
    logic              w_wr;
    logic              w_last;
    logic              w_start;
    logic              w_toggle;
    logic              w_commit;
    logic              w_adv;
    logic              w_clr;
    logic [DATA_W-1:0] w_pat_dt;
    logic [DATA_W-1:0] w_word;

    assign w_cur_len   = r_is_full ? full_len_i : short_len_i;
    assign w_wcnt_nxt  = r_wcnt + LEN_W'(1);
    assign w_fifo_rdy  = fifo_epty_i & ~fifo_full_i & ~fifo_almst_full_i;
    assign w_both_zero = (short_len_i == '0) && (full_len_i == '0);
    assign w_clr       = (r_state == ST_IDLE);

    usb_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (w_clr),
        .adv_i   (w_adv),
        .mode_i  (r_mode),
        .const_i (const_i),
        .dt_o    (w_pat_dt)
    );

`ifdef USB_PROD_HDR_EN
    logic [31:0] w_hdr;
    logic        w_hdr_word;

    // Header occupies word 1 of the packet; the pattern holds still underneath it.
    assign w_hdr      = {HDR_MAGIC, 8'(r_pkt_cnt), 16'(r_len)};
    assign w_hdr_word = (r_wcnt == '0);
    assign w_word     = w_hdr_word ? DATA_W'(w_hdr) : w_pat_dt;
    assign w_adv      = w_wr & ~w_hdr_word;
`else
    assign w_word = w_pat_dt;
    assign w_adv  = w_wr;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_last      = 1'b0;
        w_start     = 1'b0;
        w_toggle    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en_i) w_state_nxt = ST_WT_FIFO;
            end
            ST_WT_FIFO: begin
                if (!en_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_both_zero) begin
                    w_state_nxt = ST_WT_FIFO;
                end else if (w_cur_len == '0) begin
                    w_toggle = 1'b1;
                end else if (w_fifo_rdy) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_WR_PKT;
                end
            end
            ST_WR_PKT: begin
                // A full FIFO holds the current word; it is retried, never skipped.
                if (!fifo_full_i) begin
                    w_wr = 1'b1;
                    if (w_wcnt_nxt == r_len) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_WT_DONE;
                    end else if (fifo_almst_full_i) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end else if (fifo_almst_full_i) begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (!fifo_almst_full_i) w_state_nxt = ST_WR_PKT;
            end
            ST_WT_DONE: begin
                if (done_i) begin
                    w_commit    = 1'b1;
                    w_toggle    = 1'b1;
                    w_state_nxt = en_i ? ST_WT_FIFO : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_is_full <= 1'b0;
            r_len     <= '0;
            r_wcnt    <= '0;
            r_mode    <= '0;
            r_wr      <= 1'b0;
            r_dt      <= '0;
            r_last    <= 1'b0;
            r_pkt_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wr    <= w_wr;
            r_last  <= w_last;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_wr) r_dt <= w_word;

            if (r_state == ST_IDLE) r_is_full <= 1'b0;
            else if (w_toggle)      r_is_full <= ~r_is_full;

            if (w_start) begin
                r_len  <= w_cur_len;
                r_mode <= mode_i;
                r_wcnt <= '0;
            end else if (w_wr) begin
                r_wcnt <= w_wcnt_nxt;
            end

            if (w_commit) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        end
    end

    assign fifo_wr_o  = r_wr;
    assign dt_o       = r_dt;
    assign pkt_last_o = r_last;
    assign pkt_cnt_o  = r_pkt_cnt;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_usb_pattern_producer.sv
// Directed bench for usb_pattern_producer with a write scoreboard and an
// automatic FX3 commit responder (done_i pulsed 5 cycles after each last word).
module tb_usb_pattern_producer;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 10;
    localparam int CNT_W  = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              en_i;
    logic [1:0]        mode_i;
    logic [DATA_W-1:0] const_i;
    logic [LEN_W-1:0]  short_len_i;
    logic [LEN_W-1:0]  full_len_i;
    logic              done_i = 1'b0;
    logic              fifo_epty_i;
    logic              fifo_full_i;
    logic              fifo_almst_full_i;
    logic              fifo_wr_o;
    logic [DATA_W-1:0] dt_o;
    logic              pkt_last_o;
    logic [CNT_W-1:0]  pkt_cnt_o;
    logic              busy_o;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   wr_seen  = 0;

    usb_pattern_producer #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .en_i              (en_i),
        .mode_i            (mode_i),
        .const_i           (const_i),
        .short_len_i       (short_len_i),
        .full_len_i        (full_len_i),
        .done_i            (done_i),
        .fifo_epty_i       (fifo_epty_i),
        .fifo_full_i       (fifo_full_i),
        .fifo_almst_full_i (fifo_almst_full_i),
        .fifo_wr_o         (fifo_wr_o),
        .dt_o              (dt_o),
        .pkt_last_o        (pkt_last_o),
        .pkt_cnt_o         (pkt_cnt_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_writes(input string tag, input int n, input int max);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < max) begin
            @(negedge clk_i);
            cyc++;
            if (fifo_wr_o === 1'b1) seen++;
        end
        chk(tag, 64'(seen), 64'(n));
    endtask

    task automatic wait_last(input string tag, input int max);
        logic got = 1'b0;
        int   cyc = 0;
        while (!got && cyc < max) begin
            @(negedge clk_i);
            cyc++;
            got = (fifo_wr_o === 1'b1) && (pkt_last_o === 1'b1);
        end
        chk(tag, 64'(got), 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (busy_o !== 1'b0 && cyc < max);
        chk(tag, 64'(busy_o), 64'd0);
    endtask

    task automatic wait_cnt(input string tag, input int n, input int max);
        int cyc = 0;
        while (pkt_cnt_o !== CNT_W'(n) && cyc < max) begin
            @(negedge clk_i);
            cyc++;
        end
        chk(tag, 64'(pkt_cnt_o), 64'(n));
    endtask

    // Scoreboard: every write must match the next expected word and last flag.
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (fifo_wr_o === 1'b1) begin
            wr_seen++;
            chk("write_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("data", 64'(dt_o), 64'(e.d));
                chk("last", 64'(pkt_last_o), 64'(e.l));
            end
        end
    end

    // FX3 controller model: commit 5 cycles after the last word of a packet.
    always @(negedge clk_i) begin : commit
        if (fifo_wr_o === 1'b1 && pkt_last_o === 1'b1) begin
            repeat (4) @(negedge clk_i);
            done_i = 1'b1;
            @(negedge clk_i);
            done_i = 1'b0;
        end
    end

    initial begin
        int base;
        rst_i             = 1'b1;
        en_i              = 1'b0;
        mode_i            = 2'd0;
        const_i           = '0;
        short_len_i       = '0;
        full_len_i        = '0;
        fifo_epty_i       = 1'b1;
        fifo_full_i       = 1'b0;
        fifo_almst_full_i = 1'b0;
        tick(3);
        chk("rst_wr",   64'(fifo_wr_o),  64'd0);
        chk("rst_dt",   64'(dt_o),       64'd0);
        chk("rst_last", 64'(pkt_last_o), 64'd0);
        chk("rst_cnt",  64'(pkt_cnt_o),  64'd0);
        chk("rst_busy", 64'(busy_o),     64'd0);
        rst_i = 1'b0;
        tick(2);
        chk("idle_no_en", 64'(busy_o), 64'd0);

`ifndef USB_PROD_HDR_EN
        // Short then full packet, counter pattern
        short_len_i = 10'd4;
        full_len_i  = 10'd8;
        mode_i      = 2'd0;
        for (int i = 0; i < 12; i++) push(DATA_W'(i), (i == 3) || (i == 11));
        base = wr_seen;
        en_i = 1'b1;
        wait_last("t1_last_short", 40);
        wait_cnt("t1_cnt1", 1, 40);
        wait_last("t1_last_full", 60);
        en_i = 1'b0;
        wait_cnt("t1_cnt2", 2, 40);
        wait_idle("t1_idle", 20);
        chk("t1_writes", 64'(wr_seen - base), 64'd12);

        // Almost-full pause in the middle of an 8-word packet
        short_len_i = 10'd0;
        full_len_i  = 10'd8;
        for (int i = 0; i < 8; i++) push(DATA_W'(i), i == 7);
        base = wr_seen;
        en_i = 1'b1;
        wait_writes("t2_word1", 1, 40);
        fifo_almst_full_i = 1'b1;
        tick(1);
        chk("t2_word2", 64'(fifo_wr_o), 64'd1);
        tick(1);
        chk("t2_gap1", 64'(fifo_wr_o), 64'd0);
        tick(1);
        chk("t2_gap2", 64'(fifo_wr_o), 64'd0);
        fifo_almst_full_i = 1'b0;
        tick(1);
        chk("t2_gap3", 64'(fifo_wr_o), 64'd0);
        tick(1);
        chk("t2_resume", 64'(fifo_wr_o), 64'd1);
        wait_last("t2_last", 40);
        en_i = 1'b0;
        wait_cnt("t2_cnt", 3, 40);
        wait_idle("t2_idle", 20);
        chk("t2_writes", 64'(wr_seen - base), 64'd8);

        // Short length 0: only full packets, walking-one pattern
        short_len_i = 10'd0;
        full_len_i  = 10'd3;
        mode_i      = 2'd1;
        push(32'd1, 1'b0);  push(32'd2, 1'b0);  push(32'd4, 1'b1);
        push(32'd8, 1'b0);  push(32'd16, 1'b0); push(32'd32, 1'b1);
        en_i = 1'b1;
        wait_last("t3_last_a", 40);
        wait_last("t3_last_b", 40);
        en_i = 1'b0;
        wait_cnt("t3_cnt", 5, 40);
        wait_idle("t3_idle", 20);

        // en_i dropped on word 2: packet completes, then IDLE; restart from 0
        full_len_i = 10'd8;
        mode_i     = 2'd0;
        for (int i = 0; i < 8; i++) push(DATA_W'(i), i == 7);
        base = wr_seen;
        en_i = 1'b1;
        wait_writes("t4_word2", 2, 40);
        en_i = 1'b0;
        wait_last("t4_last", 40);
        chk("t4_busy_wt_done", 64'(busy_o), 64'd1);
        wait_idle("t4_idle", 20);
        chk("t4_cnt", 64'(pkt_cnt_o), 64'd6);
        chk("t4_writes", 64'(wr_seen - base), 64'd8);
        tick(3);
        chk("t4_stay_idle", 64'(busy_o), 64'd0);
        for (int i = 0; i < 8; i++) push(DATA_W'(i), i == 7);
        en_i = 1'b1;
        wait_last("t4_restart_last", 40);
        en_i = 1'b0;
        wait_cnt("t4_cnt2", 7, 40);
        wait_idle("t4_idle2", 20);

        // Reset on word 5 of 8 aborts the packet
        for (int i = 0; i < 5; i++) push(DATA_W'(i), 1'b0);
        en_i = 1'b1;
        wait_writes("t5_word5", 5, 40);
        rst_i = 1'b1;
        tick(1);
        chk("t5_wr",   64'(fifo_wr_o),  64'd0);
        chk("t5_cnt",  64'(pkt_cnt_o),  64'd0);
        chk("t5_busy", 64'(busy_o),     64'd0);
        chk("t5_last", 64'(pkt_last_o), 64'd0);
        chk("t5_dt",   64'(dt_o),       64'd0);
        en_i  = 1'b0;
        rst_i = 1'b0;
        tick(4);
        chk("t5_quiet", 64'(fifo_wr_o), 64'd0);

        // fifo_full_i holds the word; alternating pattern shows no skip
        mode_i = 2'd2;
        full_len_i = 10'd6;
        for (int i = 0; i < 6; i++) push((i % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555, i == 5);
        en_i = 1'b1;
        wait_writes("t6_word2", 2, 40);
        fifo_full_i = 1'b1;
        tick(1);
        chk("t6_full_a", 64'(fifo_wr_o), 64'd0);
        tick(1);
        chk("t6_full_b", 64'(fifo_wr_o), 64'd0);
        fifo_full_i = 1'b0;
        wait_last("t6_last", 40);
        en_i = 1'b0;
        wait_cnt("t6_cnt", 1, 40);
        wait_idle("t6_idle", 20);

        // Constant pattern
        mode_i     = 2'd3;
        const_i    = 32'hDEAD_BEEF;
        full_len_i = 10'd2;
        push(32'hDEAD_BEEF, 1'b0);
        push(32'hDEAD_BEEF, 1'b1);
        en_i = 1'b1;
        wait_last("t7_last", 40);
        en_i = 1'b0;
        wait_cnt("t7_cnt", 2, 40);
        wait_idle("t7_idle", 20);
`else
        // Header packets, each started from IDLE so the counter restarts at 0
        short_len_i = 10'd0;
        full_len_i  = 10'd4;
        mode_i      = 2'd0;
        for (int p = 0; p < 3; p++) begin
            push({8'hA5, 8'(p), 16'd4}, 1'b0);
            push(32'd0, 1'b0);
            push(32'd1, 1'b0);
            push(32'd2, 1'b1);
            en_i = 1'b1;
            wait_last("hdr_last", 40);
            en_i = 1'b0;
            wait_cnt("hdr_cnt", p + 1, 40);
            wait_idle("hdr_idle", 20);
        end
        // Header-only packet
        full_len_i = 10'd1;
        push(32'hA503_0001, 1'b1);
        en_i = 1'b1;
        wait_last("hdr_only_last", 40);
        en_i = 1'b0;
        wait_cnt("hdr_only_cnt", 4, 40);
        wait_idle("hdr_only_idle", 20);
        // fifo_full_i suppresses writes, header and pattern still in order
        full_len_i = 10'd4;
        push(32'hA504_0004, 1'b0);
        push(32'd0, 1'b0);
        push(32'd1, 1'b0);
        push(32'd2, 1'b1);
        en_i = 1'b1;
        wait_writes("hdr_full_w2", 2, 40);
        fifo_full_i = 1'b1;
        tick(1);
        chk("hdr_full_a", 64'(fifo_wr_o), 64'd0);
        tick(1);
        chk("hdr_full_b", 64'(fifo_wr_o), 64'd0);
        fifo_full_i = 1'b0;
        wait_last("hdr_full_last", 40);
        en_i = 1'b0;
        wait_idle("hdr_full_idle", 20);
`endif

        tick(2);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
